downsamp_accum: RTL and testbench

- Parametrised multi-channel integrate-and-dump decimator for the ADC front end.
- Sits between the raw ADC sample bus and the input FIFO, ahead of the Costas loop.
- Sums 2^SAMPLE_RATE consecutive samples per channel and emits a full-precision sum with a one-cycle write strobe.
- Honours the FIFO's busy signal through a one-entry holding register with overflow flagging.

---
 rtl/downsamp_accum.sv | 88 ++++++++
 tb/tb_downsamp_accum.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/downsamp_accum.sv
// downsamp_accum: multi-channel integrate-and-dump decimator with a one-entry output hold.
// Optional DOWNSAMP_DROPCNT_EN adds a saturating drop_cnt of discarded results.
module downsamp_accum #(
  parameter int DATA_WIDTH  = 12,
  parameter int SAMPLE_RATE = 2,
  parameter int CHANNELS    = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic                                          in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                dataIn,
  input  logic                                          outbusy,
  output logic [CHANNELS*(DATA_WIDTH+SAMPLE_RATE)-1:0]  dsoutdata,
  output logic                                          out_en,
  output logic                                          overflow,
`ifdef DOWNSAMP_DROPCNT_EN
  output logic [7:0]                                    drop_cnt,
`endif
  output logic [((SAMPLE_RATE > 0) ? SAMPLE_RATE : 1)-1:0] frame_phase
);
  localparam int OW = DATA_WIDTH + SAMPLE_RATE;
  localparam int PW = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
  typedef enum logic {EMPTY, HELD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CHANNELS*OW-1:0] acc_q, acc_d, hold_q, hold_d, dout_q, dout_d, result;
  logic out_en_q, out_en_d, ovf_q, ovf_d;
  logic accept, dump, emit, load_hold, drop;
  assign accept = en & in_valid;
  // With SAMPLE_RATE=0 the last phase is 0, so every accept dumps
  assign dump = accept && (phase_q == PW'((1 << SAMPLE_RATE) - 1));
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign result[c*OW +: OW] = acc_q[c*OW +: OW] + OW'($signed(dataIn[c*DATA_WIDTH +: DATA_WIDTH]));
  end
  always_comb begin
    acc_d   = !accept ? acc_q : dump ? '0 : result;
    phase_d = !accept ? phase_q : dump ? '0 : phase_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == EMPTY) ? ((dump && outbusy) ? HELD : EMPTY)
                                 : ((!outbusy && !dump) ? EMPTY : HELD);
  end
  // A held result always leaves before a newer one, preserving order
  always_comb begin
    emit      = !outbusy && (state_q == HELD || dump);
    load_hold = dump && ((state_q == EMPTY) ? outbusy : !outbusy);
    drop      = dump && outbusy && (state_q == HELD);
    dout_d    = emit ? ((state_q == HELD) ? hold_q : result) : dout_q;
    hold_d    = load_hold ? result : hold_q;
    out_en_d  = emit;
    ovf_d     = ovf_q | drop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      phase_q  <= '0;
      hold_q   <= '0;
      dout_q   <= '0;
      out_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      dout_q   <= dout_d;
      out_en_q <= out_en_d;
      ovf_q    <= ovf_d;
    end
  end
`ifdef DOWNSAMP_DROPCNT_EN
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = (drop && !(&cnt_q)) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign drop_cnt = cnt_q;
`endif
  assign dsoutdata   = dout_q;
  assign out_en      = out_en_q;
  assign overflow    = ovf_q;
  assign frame_phase = phase_q;
endmodule

// File: tb/tb_downsamp_accum.sv
// tb_downsamp_accum: scoreboard bench for downsamp_accum (SAMPLE_RATE=2 x2 channels, plus SAMPLE_RATE=0 pass-through).
module tb_downsamp_accum;
  logic clk = 1'b0;
  logic rst_n, en, in_valid, outbusy;
  logic [23:0] dataIn;
  logic [27:0] dsoutdata;
  logic out_en, overflow;
  logic [1:0] frame_phase;
`ifdef DOWNSAMP_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif
  logic en1, v1, busy1;
  logic [11:0] d1, dso1;
  logic out_en1, ovf1;
  logic [0:0] fp1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {logic [27:0] d; int at;} exp_t;
  typedef struct {logic [11:0] d; int at;} exp1_t;
  exp_t q[$];
  exp1_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  downsamp_accum #(.DATA_WIDTH(12), .SAMPLE_RATE(2), .CHANNELS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .dataIn(dataIn),
    .outbusy(outbusy), .dsoutdata(dsoutdata), .out_en(out_en), .overflow(overflow),
`ifdef DOWNSAMP_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .frame_phase(frame_phase));

  downsamp_accum #(.DATA_WIDTH(12), .SAMPLE_RATE(0), .CHANNELS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_valid(v1), .dataIn(d1),
    .outbusy(busy1), .dsoutdata(dso1), .out_en(out_en1), .overflow(ovf1),
`ifdef DOWNSAMP_DROPCNT_EN
    .drop_cnt(),
`endif
    .frame_phase(fp1));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [27:0] pk(input int a, input int b);
    return {14'(b), 14'(a)};
  endfunction

  task automatic push(input logic [27:0] d, input int at);
    q.push_back('{d: d, at: at});
  endtask

  task automatic drive(input logic e, input logic v, input logic b, input int s0, input int s1);
    en = e;
    in_valid = v;
    outbusy = b;
    dataIn = {12'(s1), 12'(s0)};
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_en) begin
      if (q.size() == 0) chk("unexpected_out_en", 32'(dsoutdata), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dsoutdata", 32'(dsoutdata), 32'(e.d));
        chk("out_latency", 32'(cyc), 32'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_en1) begin
      if (q1.size() == 0) chk("unexpected_out_en_sr0", 32'(dso1), 32'hFFFF_FFFF);
      else begin
        exp1_t e;
        e = q1.pop_front();
        chk("dsoutdata_sr0", 32'(dso1), 32'(e.d));
        chk("out_latency_sr0", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int vals [3] = '{5, -7, 9};
    rst_n = 1'b0; en = 0; in_valid = 0; outbusy = 0; dataIn = '0;
    en1 = 0; v1 = 0; d1 = '0; busy1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dsoutdata", 32'(dsoutdata), 0);
    chk("rst_out_en", 32'(out_en), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_phase", 32'(frame_phase), 0);
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) begin
        if (i == 3) push(pk(400, -200), cyc + 1);
        drive(1, 1, 0, 100, -50);
        if (f == 0 && i == 1) chk("frame_phase_mid", 32'(frame_phase), 2);
      end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(pk(-8192, 8188), cyc + 1);
      drive(1, 1, 0, -2048, 2047);
    end
    drive(1, 1, 0, 1, 10);
    drive(1, 1, 1, 2, 20);
    drive(1, 1, 1, 3, 30);
    drive(1, 1, 1, 4, 40);
    repeat (3) drive(1, 0, 1, 0, 0);
    push(pk(10, 100), cyc + 1);
    drive(0, 0, 0, 0, 0);
    chk("single_stall_overflow", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 2, 2);
    push(pk(4, 4), cyc + 1);
    drive(1, 0, 0, 0, 0);
    chk("double_stall_overflow", 32'(overflow), 1);
`ifdef DOWNSAMP_DROPCNT_EN
    chk("drop_cnt", 32'(drop_cnt), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(pk(12, 12), cyc + 1);
      drive(1, 1, 0, 3, 3);
    end
    chk("overflow_sticky", 32'(overflow), 1);
    drive(1, 1, 0, 5, 5);
    drive(1, 1, 0, 5, 5);
    en = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_dsoutdata", 32'(dsoutdata), 0);
    chk("midrst_out_en", 32'(out_en), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    chk("midrst_frame_phase", 32'(frame_phase), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(pk(28, 28), cyc + 1);
      drive(1, 1, 0, 7, 7);
    end
    drive(1, 1, 0, 1, -1);
    drive(1, 1, 0, 2, -2);
    repeat (3) drive(0, 1, 0, 100, 100);
    chk("en_low_frame_phase", 32'(frame_phase), 2);
    drive(1, 0, 0, 55, 55);
    drive(1, 1, 0, 3, -3);
    push(pk(10, -10), cyc + 1);
    drive(1, 1, 0, 4, -4);
    drive(0, 0, 0, 0, 0);
    en1 = 1;
    v1 = 1;
    for (int k = 0; k < 3; k++) begin
      q1.push_back('{d: 12'(vals[k]), at: cyc + 1});
      d1 = 12'(vals[k]);
      @(posedge clk);
      #1;
      chk("sr0_frame_phase", 32'(fp1), 0);
    end
    v1 = 0;
    repeat (3) drive(0, 0, 0, 0, 0);
    chk("queue_drained", 32'(q.size()), 0);
    chk("queue_drained_sr0", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
